ibex_rf_wb_arbiter: RTL

- Producer side of the register-file write port: merges EX single-cycle results and LSU load responses onto the single write port (waddr/wdata/we).
- LSU responses cannot be back-pressured and take priority. EX results are buffered in a small FIFO when the port is busy.
- Exposes a pending-write mask so ID can stall on RAW hazards against not-yet-committed writes.

---
 rtl/ibex_pkg.sv | 37 +++
 rtl/ibex_rf_wb_fifo.sv | 91 +++++++++
 rtl/ibex_rf_wb_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types and helpers for the register-file write-back path.
package ibex_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned RfDataW  = 32;

    // Default-width register-file write record. Blocks that carry a
    // different data width declare a local equivalent.
    typedef struct packed {
        logic [RegAddrW-1:0] waddr;
        logic [RfDataW-1:0]  wdata;
    } rf_wr_t;

    // Source feeding the write-port register in a given cycle.
    typedef enum logic [1:0] {
        WbSelNone = 2'd0,
        WbSelLsu  = 2'd1,
        WbSelFifo = 2'd2,
        WbSelEx   = 2'd3
    } wb_sel_e;

    // A write to x0, or to x16..x31 on a 16-register file, has no
    // architectural effect and is dropped at the input.
    function automatic logic rf_addr_discard(input logic [RegAddrW-1:0] addr,
                                             input logic                rv32e);
        return (addr == '0) || (rv32e && addr[RegAddrW-1]);
    endfunction

    // One-hot register mask for a write address.
    function automatic logic [31:0] rf_onehot(input logic [RegAddrW-1:0] addr);
        logic [31:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Small in-order buffer for EX results waiting for the register-file port.
// Entry 0 is always the head; a pop shifts the remaining entries down.
module ibex_rf_wb_fifo
    import ibex_pkg::*;
#(
    parameter int Depth     = 2,
    parameter int DataWidth = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               push_i,
    input  logic [RegAddrW-1:0]                push_waddr_i,
    input  logic [DataWidth-1:0]               push_wdata_i,
    input  logic                               pop_i,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [RegAddrW-1:0]                head_waddr_o,
    output logic [DataWidth-1:0]               head_wdata_o,
    output logic [Depth-1:0]                   entry_valid_o,
    output logic [Depth-1:0][RegAddrW-1:0]     entry_waddr_o
);

    localparam int CntW = $clog2(Depth + 1);

    logic [CntW-1:0]                 cnt_q, cnt_d, cnt_popped;
    logic [Depth-1:0][RegAddrW-1:0]  waddr_q, waddr_d;
    logic [Depth-1:0][DataWidth-1:0] wdata_q, wdata_d;

    assign empty_o       = (cnt_q == '0);
    assign full_o        = (cnt_q == CntW'(Depth));
    assign head_waddr_o  = waddr_q[0];
    assign head_wdata_o  = wdata_q[0];
    assign entry_waddr_o = waddr_q;

    // Entries below the occupancy count hold live writes.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            entry_valid_o[i] = (i < int'(cnt_q));
        end
    end

    // Next-state: shift on pop, write the first free slot on push, clear on flush.
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_popped = cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (pop_i && !empty_o) begin
            for (int i = 0; i < Depth - 1; i++) begin
                waddr_d[i] = waddr_q[i+1];
                wdata_d[i] = wdata_q[i+1];
            end
            cnt_popped = cnt_q - CntW'(1);
        end
        cnt_d = cnt_popped;
        if (push_i && (int'(cnt_popped) < Depth)) begin
            for (int i = 0; i < Depth; i++) begin
                if (i == int'(cnt_popped)) begin
                    waddr_d[i] = push_waddr_i;
                    wdata_d[i] = push_wdata_i;
                end
            end
            cnt_d = cnt_popped + CntW'(1);
        end
        if (flush_i) begin
            cnt_d = '0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Payload storage.
    // NOTE: payload slots are not reset; they are only observed when qualified
    // by the occupancy count, which is reset.
    always_ff @(posedge clk_i) begin
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
    end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Merges EX results and LSU load responses onto the single register-file
// write port. LSU responses cannot stall and win; EX results queue behind.
module ibex_rf_wb_arbiter
    import ibex_pkg::*;
#(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32,
    parameter int Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic [31:0]          pend_mask_o
);

    wb_sel_e                        sel;
    logic                           ex_fire, lsu_take;
    logic                           fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [RegAddrW-1:0]            head_waddr;
    logic [DataWidth-1:0]           head_wdata;
    logic [Depth-1:0]               entry_valid;
    logic [Depth-1:0][RegAddrW-1:0] entry_waddr;

    logic                           we_q, we_d;
    logic [RegAddrW-1:0]            waddr_q, waddr_d;
    logic [DataWidth-1:0]           wdata_q, wdata_d;

    // Ready depends on buffer state only, never on LSU activity.
    assign ex_ready_o = !fifo_full;

    // A discarded or flushed EX write still completes its handshake.
    assign ex_fire  = ex_valid_i & ex_ready_o & ~flush_i
                    & ~rf_addr_discard(ex_waddr_i, RV32E);
    assign lsu_take = lsu_valid_i & ~rf_addr_discard(lsu_waddr_i, RV32E);

    // Priority: LSU, then oldest queued EX, then EX bypass.
    always_comb begin
        sel = WbSelNone;
        if (lsu_take) begin
            sel = WbSelLsu;
        end else if (!fifo_empty) begin
            sel = WbSelFifo;
        end else if (ex_fire) begin
            sel = WbSelEx;
        end
    end

    assign fifo_pop  = (sel == WbSelFifo);
    assign fifo_push = ex_fire & (sel != WbSelEx);

    ibex_rf_wb_fifo #(
        .Depth     (Depth),
        .DataWidth (DataWidth)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .push_i        (fifo_push),
        .push_waddr_i  (ex_waddr_i),
        .push_wdata_i  (ex_wdata_i),
        .pop_i         (fifo_pop),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_waddr_o  (head_waddr),
        .head_wdata_o  (head_wdata),
        .entry_valid_o (entry_valid),
        .entry_waddr_o (entry_waddr)
    );

    // Load the write-port register from the selected source.
    always_comb begin
        we_d    = (sel != WbSelNone);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (sel)
            WbSelLsu:  begin waddr_d = lsu_waddr_i; wdata_d = lsu_wdata_i; end
            WbSelFifo: begin waddr_d = head_waddr;  wdata_d = head_wdata;  end
            WbSelEx:   begin waddr_d = ex_waddr_i;  wdata_d = ex_wdata_i;  end
            default:   ;
        endcase
    end

    // Registered write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_we_o    = we_q;
    assign rf_waddr_o = waddr_q;
    assign rf_wdata_o = wdata_q;

    // Pending-write mask over queued entries and the write in flight.
    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (entry_valid[i]) begin
                pend_mask_o = pend_mask_o | rf_onehot(entry_waddr[i]);
            end
        end
        if (we_q) begin
            pend_mask_o = pend_mask_o | rf_onehot(waddr_q);
        end
        pend_mask_o[0] = 1'b0;
        if (RV32E) begin
            pend_mask_o[31:16] = '0;
        end
    end

endmodule
